mem_xfer_unit: RTL and testbench
================================

// Module: mem_xfer_unit
// PURPOSE
//  Parametrised multi-beat memory transfer sequencer between the control path and the sram bus.
//  Replaces single-cycle MAR/MDR strobing with a req/done handshake and configurable wait states.
//  Handles little-endian multi-byte transfers (e.g. 16-bit immediates, PUSH/POP pairs) with address
//  auto-increment, so the control path issues one request per operand instead of one per byte.
// PARAMETERS
//  ADDR_W       16  address width; address arithmetic wraps modulo 2**ADDR_W
//  DATA_W       8   width of one memory beat
//  MAX_BEATS    2   maximum beats per transfer (>=1)
//  WAIT_STATES  0   extra cycles each beat's strobe is held before data is captured/committed
//  LEN_W        $clog2(MAX_BEATS)+1 (derived) width of len
// PORTS
//  clk        in   1                   rising-edge clock
//  rst        in   1                   asynchronous, active-high reset
//  req        in   1                   transfer request, sampled only in IDLE
//  we         in   1                   1 = write, 0 = read (latched at accept)
//  addr       in   ADDR_W              base address of beat 0 (latched at accept)
//  len        in   LEN_W               beat count, legal 1..MAX_BEATS (latched at accept)
//  wdata      in   MAX_BEATS*DATA_W    write data; beat i = wdata[i*DATA_W +: DATA_W]
//  busy       out  1                   high from cycle after accept until done cycle inclusive
//  done       out  1                   one-cycle completion pulse
//  err        out  1                   high with done when len was illegal
//  rdata      out  MAX_BEATS*DATA_W    read data, beat i in rdata[i*DATA_W +: DATA_W]
//  mem_addr   out  ADDR_W              sram address
//  mem_wdata  out  DATA_W              sram write data
//  mem_re     out  1                   sram read strobe
//  mem_we     out  1                   sram write strobe
//  mem_rdata  in   DATA_W              sram read data, valid while mem_re high
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy, done, err, mem_re, mem_we = 0; rdata, mem_addr, mem_wdata = 0.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE:
//   - req=1 at an edge latches we, addr, len and wdata; clears beat=0 and wcnt=0; goes to ACCESS.
//   - If len==0 or len>MAX_BEATS: err latched and one beat performed.
//   - Read accept clears all of rdata to 0.
//  ACCESS:
//   - mem_addr = addr_q + beat (mod 2**ADDR_W); mem_wdata = wdata_q beat slice.
//   - mem_re = !we_q; mem_we = we_q; exactly one strobe high.
//   - Each beat holds its strobe for WAIT_STATES+1 cycles (wcnt counts 0..WAIT_STATES).
//   - Final cycle of a beat: a read captures mem_rdata into rdata beat slice; a write is committed
//     by sram on that edge.
//   - Then: beat+1 < len_eff -> stay in ACCESS with beat++ and wcnt=0 (strobes stay high, address
//     steps, no idle gap); otherwise go to DONE.
//  DONE:
//   - done=1 for exactly one cycle, err=err_q, strobes low, busy=1; then IDLE.
//   - busy deasserts the cycle after done.
//   - rdata holds until the next read accept.
//  Latency: req edge N -> first strobe cycle N+1 -> done at cycle N+1+len_eff*(WAIT_STATES+1).
//  req while busy: ignored, not queued. req high in the DONE cycle: ignored.
//   - Back-to-back throughput is therefore one transfer per len*(WAIT_STATES+1)+2 cycles.
//  Inputs other than req/mem_rdata are don't-care after accept (all latched).
//  Address wrap: base 0xFFFF, len 2 -> beats at 0xFFFF then 0x0000; no error.
//  Reset mid-transfer:
//   - Strobes drop asynchronously and no done is produced; a partial write stays in memory.
//   - The transfer is not resumed.
//  Beat order is strictly ascending address, low byte first (little-endian).
// TESTING
//  1. W=0, read len=1 @0x0100, mem[0x0100]=0x3E, req @N -> mem_re cycle N+1; done @N+2;
//     rdata=0x003E, err=0.
//  2. W=0, write len=2 @0xC000, wdata=0xBEEF -> mem_we 2 cycles, addr 0xC000/0xC001, data 0xEF then
//     0xBE; done @N+3.
//  3. WAIT_STATES=2, read len=2 @0xFFFF, mem[0xFFFF]=0x12, mem[0x0000]=0x34 -> strobe 6 cycles,
//     addr wraps to 0x0000; rdata=0x3412; done @N+7.
//  4. req held high continuously, len=1 reads, W=0 -> accepts every 3 cycles; busy never drops
//     mid-transfer; no double done.
//  5. len=0 read @0x0200 -> single beat at 0x0200; done with err=1; next legal transfer has err=0.
//  6. Async rst asserted in 2nd beat of len=2 write -> strobes 0 same cycle; busy=0, done never
//     pulses; mem[addr] written, mem[addr+1] unchanged.

Source files
------------

// File: rtl/mem_xfer_unit.sv
// Multi-beat memory transfer sequencer: one req/done handshake per operand, little-endian
// beats with address auto-increment and a fixed number of wait states per beat.
module mem_xfer_unit #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MAX_BEATS   = 2,
  parameter int WAIT_STATES = 0,
  parameter int LEN_W       = $clog2(MAX_BEATS) + 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req,
  input  logic                          i_we,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [LEN_W-1:0]              i_len,
  input  logic [MAX_BEATS*DATA_W-1:0]   i_wdata,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [MAX_BEATS*DATA_W-1:0]   o_rdata,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  output logic                          o_mem_re,
  output logic                          o_mem_we,
  input  logic [DATA_W-1:0]             i_mem_rdata
);

  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_STATES);
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                        r_state;
  state_t                        w_nextState;
  logic                          r_we;
  logic                          r_err;
  logic [ADDR_W-1:0]             r_addr;
  logic [LEN_W-1:0]              r_lenEff;
  logic [LEN_W-1:0]              r_beat;
  logic [WCNT_W-1:0]             r_wcnt;
  logic [MAX_BEATS*DATA_W-1:0]   r_wdata;
  logic [MAX_BEATS*DATA_W-1:0]   r_rdata;

  logic                          w_lenIllegal;
  logic                          w_beatLast;
  logic                          w_moreBeats;
  logic [DATA_W-1:0]             w_beatData;

  // An illegal length still performs one beat so the bus sees a normal transaction.
  assign w_lenIllegal = (i_len == '0) || (i_len > MAX_LEN);
  assign w_beatLast   = (r_wcnt == WCNT_LAST);
  assign w_moreBeats  = (r_beat + LEN_W'(1)) < r_lenEff;
  assign o_rdata      = r_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_nextState = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_busy   = 1'b1;
        o_mem_re = !r_we;
        o_mem_we = r_we;
        if (w_beatLast && !w_moreBeats) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        o_err       = r_err;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_beatData = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (r_beat == LEN_W'(i)) begin
        w_beatData = r_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Bus address/data are forced to zero outside ACCESS so reset clears them immediately.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (r_state == S_ACCESS) begin
      o_mem_addr  = r_addr + ADDR_W'(r_beat);
      o_mem_wdata = w_beatData;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_lenEff <= '0;
      r_beat   <= '0;
      r_wcnt   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we     <= i_we;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_err    <= w_lenIllegal;
            r_lenEff <= w_lenIllegal ? LEN_W'(1) : i_len;
            r_beat   <= '0;
            r_wcnt   <= '0;
            if (!i_we) begin
              r_rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (!w_beatLast) begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end else begin
            if (!r_we) begin
              for (int i = 0; i < MAX_BEATS; i++) begin
                if (r_beat == LEN_W'(i)) begin
                  r_rdata[i*DATA_W +: DATA_W] <= i_mem_rdata;
                end
              end
            end
            if (w_moreBeats) begin
              r_beat <= r_beat + LEN_W'(1);
              r_wcnt <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Directed bench for mem_xfer_unit: one zero-wait-state instance and one with two wait states,
// each attached to its own behavioural sram.
module tb_mem_xfer_unit;

  logic        clk;
  logic        rst;
  logic        req0;
  logic        req2;
  logic        we;
  logic [15:0] addr;
  logic [1:0]  len;
  logic [15:0] wdata;

  logic        busy0, done0, err0, memRe0, memWe0;
  logic [15:0] rdata0, memAddr0;
  logic [7:0]  memWdata0, memRdata0;
  logic        busy2, done2, err2, memRe2, memWe2;
  logic [15:0] rdata2, memAddr2;
  logic [7:0]  memWdata2, memRdata2;

  logic        pokeEn0, pokeEn2;
  logic [15:0] pokeAddr;
  logic [7:0]  pokeData;
  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem2 [0:65535];

  int testsRun;
  int testsFailed;

  mem_xfer_unit #(.ADDR_W(16), .DATA_W(8), .MAX_BEATS(2), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .o_busy(busy0), .o_done(done0), .o_err(err0), .o_rdata(rdata0),
    .o_mem_addr(memAddr0), .o_mem_wdata(memWdata0), .o_mem_re(memRe0), .o_mem_we(memWe0),
    .i_mem_rdata(memRdata0)
  );

  mem_xfer_unit #(.ADDR_W(16), .DATA_W(8), .MAX_BEATS(2), .WAIT_STATES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_we(we), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .o_busy(busy2), .o_done(done2), .o_err(err2), .o_rdata(rdata2),
    .o_mem_addr(memAddr2), .o_mem_wdata(memWdata2), .o_mem_re(memRe2), .o_mem_we(memWe2),
    .i_mem_rdata(memRdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each sram has a single writer process: bench preloads take priority over the DUT strobe.
  always @(posedge clk) begin
    if (pokeEn0) mem0[pokeAddr] <= pokeData;
    else if (memWe0) mem0[memAddr0] <= memWdata0;
  end

  always @(posedge clk) begin
    if (pokeEn2) mem2[pokeAddr] <= pokeData;
    else if (memWe2) mem2[memAddr2] <= memWdata2;
  end

  assign memRdata0 = mem0[memAddr0];
  assign memRdata2 = mem2[memAddr2];

  task automatic pokeMem(input bit toDut2, input logic [15:0] a, input logic [7:0] d);
    pokeAddr = a;
    pokeData = d;
    if (toDut2) pokeEn2 = 1'b1;
    else pokeEn0 = 1'b1;
    @(negedge clk);
    pokeEn0 = 1'b0;
    pokeEn2 = 1'b0;
  endtask

  task automatic test_reset;
    testsRun++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_status: busy=%b done=%b err=%b, want 0 0 0", busy0, done0, err0);
    end
    testsRun++;
    if (memRe0 !== 1'b0 || memWe0 !== 1'b0 || memAddr0 !== 16'h0 || memWdata0 !== 8'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_bus: re=%b we=%b addr=%h wdata=%h, want all 0",
               memRe0, memWe0, memAddr0, memWdata0);
    end
    testsRun++;
    if (rdata0 !== 16'h0 || rdata2 !== 16'h0 || busy2 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rdata: rdata0=%h rdata2=%h busy2=%b, want 0000 0000 0",
               rdata0, rdata2, busy2);
    end
  endtask

  task automatic test_read_single;
    pokeMem(1'b0, 16'h0100, 8'h3E);
    we = 1'b0; addr = 16'h0100; len = 2'd1; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; addr = 16'h0000;
    testsRun++;
    if (memRe0 !== 1'b1 || memWe0 !== 1'b0 || memAddr0 !== 16'h0100 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL read1_strobe: re=%b we=%b addr=%h busy=%b done=%b, want 1 0 0100 1 0",
               memRe0, memWe0, memAddr0, busy0, done0);
    end
    @(negedge clk);
    testsRun++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || rdata0 !== 16'h003E || memRe0 !== 1'b0 || busy0 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL read1_done: done=%b err=%b rdata=%h re=%b busy=%b, want 1 0 003e 0 1",
               done0, err0, rdata0, memRe0, busy0);
    end
    @(negedge clk);
    testsRun++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL read1_idle: busy=%b done=%b, want 0 0", busy0, done0);
    end
  endtask

  task automatic test_write_pair;
    pokeMem(1'b0, 16'hC000, 8'h00);
    pokeMem(1'b0, 16'hC001, 8'h00);
    we = 1'b1; addr = 16'hC000; len = 2'd2; wdata = 16'hBEEF; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    testsRun++;
    if (memWe0 !== 1'b1 || memRe0 !== 1'b0 || memAddr0 !== 16'hC000 || memWdata0 !== 8'hEF) begin
      testsFailed++;
      $display("[TB] FAIL write_beat0: we=%b re=%b addr=%h data=%h, want 1 0 c000 ef",
               memWe0, memRe0, memAddr0, memWdata0);
    end
    @(negedge clk);
    testsRun++;
    if (memWe0 !== 1'b1 || memAddr0 !== 16'hC001 || memWdata0 !== 8'hBE || done0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL write_beat1: we=%b addr=%h data=%h done=%b, want 1 c001 be 0",
               memWe0, memAddr0, memWdata0, done0);
    end
    @(negedge clk);
    testsRun++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || memWe0 !== 1'b0 || rdata0 !== 16'h003E) begin
      testsFailed++;
      $display("[TB] FAIL write_done: done=%b err=%b we=%b rdata=%h, want 1 0 0 003e",
               done0, err0, memWe0, rdata0);
    end
    testsRun++;
    if (mem0[16'hC000] !== 8'hEF || mem0[16'hC001] !== 8'hBE) begin
      testsFailed++;
      $display("[TB] FAIL write_mem: c000=%h c001=%h, want ef be", mem0[16'hC000], mem0[16'hC001]);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_wrap;
    pokeMem(1'b1, 16'hFFFF, 8'h12);
    pokeMem(1'b1, 16'h0000, 8'h34);
    we = 1'b0; addr = 16'hFFFF; len = 2'd2; req2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req2 = 1'b0;
      testsRun++;
      if (memRe2 !== 1'b1 || done2 !== 1'b0 || busy2 !== 1'b1 ||
          memAddr2 !== ((k <= 3) ? 16'hFFFF : 16'h0000)) begin
        testsFailed++;
        $display("[TB] FAIL wait_strobe cycle %0d: re=%b done=%b busy=%b addr=%h, want 1 0 1 %h",
                 k, memRe2, done2, busy2, memAddr2, (k <= 3) ? 16'hFFFF : 16'h0000);
      end
    end
    @(negedge clk);
    testsRun++;
    if (done2 !== 1'b1 || err2 !== 1'b0 || rdata2 !== 16'h3412 || memRe2 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wait_done: done=%b err=%b rdata=%h re=%b, want 1 0 3412 0",
               done2, err2, rdata2, memRe2);
    end
    @(negedge clk);
  endtask

  task automatic test_len_error;
    pokeMem(1'b0, 16'h0200, 8'h5A);
    pokeMem(1'b0, 16'h0201, 8'h77);
    for (int t = 0; t < 3; t++) begin
      we = 1'b0;
      len  = (t == 0) ? 2'd0 : ((t == 1) ? 2'd3 : 2'd1);
      addr = (t == 2) ? 16'h0201 : 16'h0200;
      req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0;
      testsRun++;
      if (memRe0 !== 1'b1 || memAddr0 !== addr) begin
        testsFailed++;
        $display("[TB] FAIL len_beat case %0d: re=%b addr=%h, want 1 %h", t, memRe0, memAddr0, addr);
      end
      @(negedge clk);
      testsRun++;
      if (done0 !== 1'b1 || err0 !== (t != 2) || memRe0 !== 1'b0 ||
          rdata0 !== ((t == 2) ? 16'h0077 : 16'h005A)) begin
        testsFailed++;
        $display("[TB] FAIL len_done case %0d: done=%b err=%b re=%b rdata=%h, want 1 %b 0 %h",
                 t, done0, err0, memRe0, rdata0, (t != 2), (t == 2) ? 16'h0077 : 16'h005A);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_read_clear;
    pokeMem(1'b0, 16'h0300, 8'h11);
    pokeMem(1'b0, 16'h0301, 8'h22);
    we = 1'b0; addr = 16'h0300; len = 2'd2; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    testsRun++;
    if (done0 !== 1'b1 || rdata0 !== 16'h2211) begin
      testsFailed++;
      $display("[TB] FAIL read2_done: done=%b rdata=%h, want 1 2211", done0, rdata0);
    end
    repeat (2) @(negedge clk);
    testsRun++;
    if (rdata0 !== 16'h2211 || busy0 !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL read2_hold: rdata=%h busy=%b, want 2211 0", rdata0, busy0);
    end
    addr = 16'h0100; len = 2'd1; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    testsRun++;
    if (rdata0 !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL read_clear: rdata=%h after accept, want 0000", rdata0);
    end
    @(negedge clk);
    testsRun++;
    if (done0 !== 1'b1 || rdata0 !== 16'h003E) begin
      testsFailed++;
      $display("[TB] FAIL read_clear_done: done=%b rdata=%h, want 1 003e", done0, rdata0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int doneCount;
    logic expBusy, expRe, expDone;
    doneCount = 0;
    we = 1'b0; addr = 16'h0100; len = 2'd1; req0 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      expBusy = (k % 3) != 0;
      expRe   = (k % 3) == 1;
      expDone = (k % 3) == 2;
      if (done0 === 1'b1) doneCount++;
      testsRun++;
      if (busy0 !== expBusy || memRe0 !== expRe || done0 !== expDone) begin
        testsFailed++;
        $display("[TB] FAIL b2b cycle %0d: busy=%b re=%b done=%b, want %b %b %b",
                 k, busy0, memRe0, done0, expBusy, expRe, expDone);
      end
    end
    req0 = 1'b0;
    testsRun++;
    if (doneCount != 3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: %0d done pulses, want 3", doneCount);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int doneSeen;
    doneSeen = 0;
    pokeMem(1'b0, 16'h4000, 8'h00);
    pokeMem(1'b0, 16'h4001, 8'hFF);
    we = 1'b1; addr = 16'h4000; len = 2'd2; wdata = 16'hA55A; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    testsRun++;
    if (memWe0 !== 1'b1 || memAddr0 !== 16'h4001) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_beat1: we=%b addr=%h, want 1 4001", memWe0, memAddr0);
    end
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (memWe0 !== 1'b0 || memRe0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || memAddr0 !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_async: we=%b re=%b busy=%b done=%b addr=%h, want 0 0 0 0 0000",
               memWe0, memRe0, busy0, done0, memAddr0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done0 === 1'b1 || busy0 === 1'b1) doneSeen++;
    end
    testsRun++;
    if (doneSeen != 0) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_resume: %0d cycles with busy/done after reset, want 0", doneSeen);
    end
    testsRun++;
    if (mem0[16'h4000] !== 8'h5A || mem0[16'h4001] !== 8'hFF) begin
      testsFailed++;
      $display("[TB] FAIL rstmid_mem: 4000=%h 4001=%h, want 5a ff", mem0[16'h4000], mem0[16'h4001]);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    req0 = 1'b0; req2 = 1'b0; we = 1'b0;
    addr = 16'h0; len = 2'd0; wdata = 16'h0;
    pokeEn0 = 1'b0; pokeEn2 = 1'b0; pokeAddr = 16'h0; pokeData = 8'h0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_read_single;
    test_write_pair;
    test_wait_wrap;
    test_len_error;
    test_read_clear;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
